// File: rtl/systolic_seq_ctrl_if.sv
// Handshake bundle for systolic_seq_ctrl: operand input stream and result transmit stream.
// slave = controller side (takes in_valid/tx_ready), master = datapath/environment side.
interface systolic_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic tx_valid;
    logic tx_ready;

    modport slave (
        input  in_valid,
        input  tx_ready,
        output in_ready,
        output tx_valid
    );

    modport master (
        output in_valid,
        output tx_ready,
        input  in_ready,
        input  tx_valid
    );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequencer for the NxN systolic MAC array (load A, load B,
// skewed compute window, result capture, paced result transmit).
// Ports: clk, reset (sync, active-high), start, flush; hs (in_valid/in_ready,
// tx_valid/tx_ready); a_wr_en, b_wr_en, wr_idx; array_clr, array_en, step_idx;
// buf_load; tx_idx; tx_done (pulse); busy.
// Optional macro SYSTOLIC_CTRL_PERF_EN adds perf_cycles / perf_stalls.
module systolic_seq_ctrl #(
    parameter int N         = 4,
    parameter int IN_BEATS  = 2,
    parameter int OUT_BEATS = 4,
    localparam int STEPS = 3 * N - 2,
    localparam int WW    = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1,
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1,
    localparam int TW    = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 flush,
    systolic_seq_ctrl_if.slave   hs,
    output logic                 a_wr_en,
    output logic                 b_wr_en,
    output logic [WW-1:0]        wr_idx,
    output logic                 array_clr,
    output logic                 array_en,
    output logic [SW-1:0]        step_idx,
    output logic                 buf_load,
    output logic [TW-1:0]        tx_idx,
    output logic                 tx_done,
`ifdef SYSTOLIC_CTRL_PERF_EN
    output logic [31:0]          perf_cycles,
    output logic [31:0]          perf_stalls,
`endif
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        DRAIN,
        TX
    } state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] beat_q, beat_d;
    logic [SW-1:0] step_q, step_d;
    logic [TW-1:0] tx_q, tx_d;
    logic          done_q, done_d;

    logic beat_last;
    logic step_last;
    logic tx_last;

    assign beat_last = (beat_q == WW'(IN_BEATS - 1));
    assign step_last = (step_q == SW'(STEPS - 1));
    assign tx_last   = (tx_q == TW'(OUT_BEATS - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            step_q  <= '0;
            tx_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            step_q  <= step_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        step_d  = step_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        if (flush) begin
            // abort wins over start and over any in-flight transfer
            state_d = IDLE;
            beat_d  = '0;
            step_d  = '0;
            tx_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) state_d = LOAD_A;
                end
                LOAD_A: begin
                    if (hs.in_valid) begin
                        if (beat_last) begin
                            beat_d  = '0;
                            state_d = LOAD_B;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                LOAD_B: begin
                    if (hs.in_valid) begin
                        if (beat_last) begin
                            beat_d  = '0;
                            state_d = COMPUTE;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
                COMPUTE: begin
                    if (step_last) begin
                        step_d  = '0;
                        state_d = DRAIN;
                    end else begin
                        step_d = step_q + 1'b1;
                    end
                end
                DRAIN: begin
                    state_d = TX;
                end
                TX: begin
                    if (hs.tx_ready) begin
                        if (tx_last) begin
                            tx_d    = '0;
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            tx_d = tx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign hs.in_ready = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign a_wr_en     = hs.in_valid && (state_q == LOAD_A);
    assign b_wr_en     = hs.in_valid && (state_q == LOAD_B);
    assign wr_idx      = beat_q;
    assign array_en    = (state_q == COMPUTE);
    assign array_clr   = (state_q == COMPUTE) && (step_q == '0);
    assign step_idx    = step_q;
    assign buf_load    = (state_q == DRAIN);
    assign hs.tx_valid = (state_q == TX);
    assign tx_idx      = tx_q;
    assign tx_done     = done_q;
    assign busy        = (state_q != IDLE);

`ifdef SYSTOLIC_CTRL_PERF_EN
    logic stall;

    assign stall = (hs.in_ready && !hs.in_valid) ||
                   (hs.tx_valid && !hs.tx_ready);

    // The start edge itself counts as the first job cycle.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state_q == IDLE) begin
            if (start) begin
                perf_cycles <= 32'd1;
                perf_stalls <= '0;
            end
        end else begin
            if (perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
            if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed self-checking bench for systolic_seq_ctrl.
// Linear directed steps with immediate assertions at each check point.
module tb_systolic_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       flush;
    logic       a_wr_en;
    logic       b_wr_en;
    logic [0:0] wr_idx;
    logic       array_clr;
    logic       array_en;
    logic [3:0] step_idx;
    logic       buf_load;
    logic [1:0] tx_idx;
    logic       tx_done;
    logic       busy;
`ifdef SYSTOLIC_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stalls;
`endif

    int vecs = 0;
    int miss = 0;
    int cyc  = 0;

    systolic_seq_ctrl_if hs ();

    systolic_seq_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .flush     (flush),
        .hs        (hs),
        .a_wr_en   (a_wr_en),
        .b_wr_en   (b_wr_en),
        .wr_idx    (wr_idx),
        .array_clr (array_clr),
        .array_en  (array_en),
        .step_idx  (step_idx),
        .buf_load  (buf_load),
        .tx_idx    (tx_idx),
        .tx_done   (tx_done),
`ifdef SYSTOLIC_CTRL_PERF_EN
        .perf_cycles (perf_cycles),
        .perf_stalls (perf_stalls),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        vecs++;
        assert (obs === want) else begin
            miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] all_outs();
        return {16'd0, hs.in_ready, a_wr_en, b_wr_en, wr_idx, array_clr,
                array_en, step_idx, buf_load, hs.tx_valid, tx_idx,
                tx_done, busy};
    endfunction

    // Runs one job from an IDLE cycle. gap cycles of in_valid=0 follow each
    // of the first ngaps beats; tx_ready drops stall_len cycles at beat
    // stall_at; flush_at aborts at that compute step; rst_at resets at
    // that tx beat.
    task automatic run_job(input int gap, input int ngaps,
                           input int stall_at, input int stall_len,
                           input int flush_at, input int rst_at,
                           input bit start_in_b, input bit start_on_done);
        int t0;
        int j;
        int stalled;
        int exp_len;
        start = 1'b1;
        hs.tx_ready = 1'b1;
        tick;
        start = 1'b0;
        t0 = cyc;
        chk("load_busy", 32'(busy), 32'd1);
        for (int b = 0; b < 4; b++) begin
            hs.in_valid = 1'b1;
            if (start_in_b && b == 2) start = 1'b1;
            #1;
            chk("in_ready", 32'(hs.in_ready), 32'd1);
            chk("a_wr_en", 32'(a_wr_en), 32'(b < 2));
            chk("b_wr_en", 32'(b_wr_en), 32'(b >= 2));
            chk("wr_idx", 32'(wr_idx), 32'(b % 2));
            tick;
            start = 1'b0;
            if (b < ngaps) begin
                for (int g = 0; g < gap; g++) begin
                    hs.in_valid = 1'b0;
                    #1;
                    chk("gap_ready", 32'(hs.in_ready), 32'd1);
                    chk("gap_wr", 32'({a_wr_en, b_wr_en}), 32'd0);
                    chk("gap_idx", 32'(wr_idx), 32'((b + 1) % 2));
                    tick;
                end
            end
        end
        hs.in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("array_en", 32'(array_en), 32'd1);
            chk("array_clr", 32'(array_clr), 32'(i == 0));
            chk("step_idx", 32'(step_idx), 32'(i));
            if (i == flush_at) begin
                flush = 1'b1;
                tick;
                flush = 1'b0;
                #1;
                chk("flush_busy", 32'(busy), 32'd0);
                chk("flush_en", 32'(array_en), 32'd0);
                tick;
                chk("flush_load", 32'(buf_load), 32'd0);
                chk("flush_done", 32'(tx_done), 32'd0);
                return;
            end
            tick;
        end
        #1;
        chk("buf_load", 32'(buf_load), 32'd1);
        chk("drain_en", 32'(array_en), 32'd0);
        chk("drain_txv", 32'(hs.tx_valid), 32'd0);
        tick;
        j = 0;
        stalled = 0;
        while (j < 4) begin
            if (j == stall_at && stalled < stall_len) begin
                hs.tx_ready = 1'b0;
                stalled++;
            end else begin
                hs.tx_ready = 1'b1;
            end
            #1;
            chk("tx_valid", 32'(hs.tx_valid), 32'd1);
            chk("tx_idx", 32'(tx_idx), 32'(j));
            if (j == rst_at) begin
                reset = 1'b1;
                tick;
                reset = 1'b0;
                #1;
                chk("rst_outs", all_outs(), 32'd0);
                return;
            end
            if (hs.tx_ready) j++;
            tick;
        end
        #1;
        exp_len = 20 + gap * ngaps + ((stall_at >= 0) ? stall_len : 0);
        chk("tx_done", 32'(tx_done), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("job_len", 32'(cyc - t0 + 1), 32'(exp_len));
`ifdef SYSTOLIC_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, 32'(exp_len));
        chk("perf_stalls", perf_stalls, 32'(exp_len - 20));
`endif
        if (start_on_done) begin
            start = 1'b1;
            tick;
            start = 1'b0;
            #1;
            chk("b2b_busy", 32'(busy), 32'd1);
            chk("b2b_ready", 32'(hs.in_ready), 32'd1);
            chk("b2b_idx", 32'(wr_idx), 32'd0);
            chk("b2b_done", 32'(tx_done), 32'd0);
            flush = 1'b1;
            tick;
            flush = 1'b0;
            #1;
            chk("b2b_flush", 32'(busy), 32'd0);
        end else begin
            tick;
            chk("done_pulse", 32'(tx_done), 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        hs.in_valid = 1'b0;
        hs.tx_ready = 1'b0;
        tick;
        chk("reset_outs1", all_outs(), 32'd0);
        tick;
        chk("reset_outs2", all_outs(), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(hs.in_ready), 32'd0);
        end
        start = 1'b1;
        flush = 1'b1;
        tick;
        start = 1'b0;
        flush = 1'b0;
        #1;
        chk("start_flush", 32'(busy), 32'd0);
        run_job(0, 0, -1, 0, -1, -1, 1'b0, 1'b0);
        run_job(3, 3, 2, 2, -1, -1, 1'b0, 1'b0);
        run_job(0, 0, -1, 0, 5, -1, 1'b0, 1'b0);
        run_job(0, 0, -1, 0, -1, -1, 1'b0, 1'b0);
        run_job(0, 0, -1, 0, -1, 1, 1'b1, 1'b0);
        run_job(0, 0, -1, 0, -1, -1, 1'b0, 1'b1);
        run_job(3, 1, -1, 0, -1, -1, 1'b0, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule

// File: doc/systolic_seq_ctrl.md
Name: systolic_seq_ctrl

Overview:
Sequencing controller for the 4x4 systolic MAC array datapath. It accepts operand beats over a valid/ready input stream and steers them into the A and B operand buffers. It then runs the array for the exact skewed compute window, strobes the result buffer load, and paces 64-bit result beats out over a valid/ready transmit interface. It is control-only: it carries no data, and drives write enables, indices and strobes consumed by the array, buffer and feeder datapath inside the top level.

Parameters:
N, 4, array dimension (N x N PEs); compute window = 3*N-2 cycles
IN_BEATS, 2, 64-bit beats per operand matrix (N*N 8-bit elements / 8)
OUT_BEATS, 4, 64-bit beats per result (N*N 16-bit accumulators / 4)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  begin a job; sampled only in IDLE
flush  in  1  synchronous abort to IDLE; priority below reset
in_valid  in  1  operand beat valid
in_ready  out  1  controller accepts operand beat
a_wr_en  out  1  write current beat into A buffer
b_wr_en  out  1  write current beat into B buffer
wr_idx  out  $clog2(IN_BEATS)  beat index within current matrix
array_clr  out  1  clear PE accumulators
array_en  out  1  advance array one step
step_idx  out  $clog2(3*N-2)  current compute step
buf_load  out  1  capture array outputs into result buffer
tx_valid  out  1  result beat valid on datapath data_out
tx_ready  in  1  downstream accepts result beat
tx_idx  out  $clog2(OUT_BEATS)  result beat select
tx_done  out  1  one-cycle pulse, job complete
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- States: IDLE, LOAD_A, LOAD_B, COMPUTE, DRAIN, TX. Moore-decoded from the state register unless noted.
- Reset: state=IDLE, counters=0. On the next edge all outputs are 0.
- IDLE: in_ready=0. start=1 moves to LOAD_A.
- LOAD_A / LOAD_B:
  - in_ready=1. A beat is accepted on an edge with in_valid&in_ready.
  - a_wr_en = in_valid & (state==LOAD_A); b_wr_en likewise for LOAD_B. Both are combinational.
  - wr_idx = beat counter. It increments per accept and wraps to 0 after IN_BEATS-1.
  - The last A accept moves to LOAD_B. The last B accept moves to COMPUTE.
  - in_valid=0 stalls indefinitely with no state change.
- COMPUTE:
  - Lasts exactly 3*N-2 cycles (10 at default).
  - array_en=1 throughout. array_clr=1 in the first COMPUTE cycle only.
  - step_idx counts 0..3*N-3. Not stallable.
- DRAIN: 1 cycle, buf_load=1.
- TX:
  - tx_valid=1. A beat is transferred on an edge with tx_valid&tx_ready; tx_idx then increments.
  - tx_ready=0 holds tx_idx and tx_valid.
  - The last beat transfer moves to IDLE, and registered tx_done=1 for the first IDLE cycle.
- Latency: last B accept at edge k gives array_en in cycles k..k+9, buf_load at cycle k+10, and tx_valid from cycle k+11 (default N).
- start outside IDLE is ignored; no queuing.
- flush:
  - From any state: IDLE on the next edge, counters cleared.
  - No tx_done is produced.
  - Any partially written buffer contents are stale and are overwritten by the next job.
- reset with flush: reset wins; the result is identical anyway.
- start and flush together in IDLE: flush wins and the controller stays in IDLE.
- Reset mid-job: same as flush. The datapath is not required to be cleared; array_clr on the next job handles that.
- Back-to-back: start in the cycle tx_done is high is accepted (that cycle is IDLE).

Optional Feature:
Macro SYSTOLIC_CTRL_PERF_EN.
- Defined:
  - Adds outputs perf_cycles[31:0] and perf_stalls[31:0].
  - perf_cycles counts cycles from leaving IDLE to tx_done. perf_stalls counts LOAD cycles with in_valid=0 plus TX cycles with tx_ready=0.
  - Both counters are frozen at tx_done and cleared on the next start, reset or flush. They saturate at 2^32-1.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset hold 2 cycles -> every output 0, busy=0. start=0 for 5 cycles -> stays IDLE, in_ready=0.
- start, then 4 consecutive in_valid beats (data 64'hCAFEBABEDEADBEEF...) and tx_ready=1:
  - a_wr_en with wr_idx 0,1, then b_wr_en with wr_idx 0,1.
  - array_clr in 1 cycle; array_en for 10 cycles; buf_load 1 cycle.
  - tx_valid 4 cycles with tx_idx 0..3, then tx_done pulse. Total 20 cycles from start edge to tx_done.
- in_valid gaps of 3 cycles between beats -> in_ready stays 1, no write strobes in gaps, wr_idx unchanged. tx_ready low 2 cycles on beat 2 -> tx_idx held at 2.
- flush asserted during COMPUTE step 5 -> IDLE next cycle, array_en=0, no buf_load, no tx_done. Next start runs a full clean job.
- reset asserted mid-TX at tx_idx=1 -> all outputs 0 next cycle. start during LOAD_B is ignored; a new start on the tx_done cycle begins LOAD_A next cycle.
- With SYSTOLIC_CTRL_PERF_EN and zero stalls -> perf_cycles=20, perf_stalls=0. With 3 input gap cycles -> perf_stalls=3.
